mux4_rr_arbiter: RTL

//  Round-robin arbiter and sequencer for the 2-bit 4-to-1 switch multiplexer.

---
 rtl/mux4_rr_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter and sequencer for a 4-to-1 switch multiplexer
// Grants one of four requesters at a time, caps tenure at HOLD_CYCLES and registers the selected word.
module mux4_rr_arbiter #(
    parameter int W           = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [3:0]     i_req,
    input  logic [4*W-1:0] i_din,
    output logic [1:0]     o_sel,
    output logic [3:0]     o_gnt,
    output logic [W-1:0]   o_dout,
    output logic           o_dout_valid,
    output logic           o_busy
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [1:0]    r_sel;
    logic [1:0]    r_last;
    logic [3:0]    r_gnt;
    logic [W-1:0]  r_dout;
    logic          r_dout_valid;
    logic [HW-1:0] r_hold_cnt;

    logic [1:0]    w_pick_base;
    logic [1:0]    w_pick;
    logic          w_any;
    logic          w_release;

    // Scan last+1, last+2, last+3, last; iterating backwards lets the earliest hit win.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    // A grant ending on release arbitrates as if last were the outgoing requester.
    assign w_pick_base = (r_state == S_GRANT) ? r_sel : r_last;
    assign w_pick      = rr_pick(i_req, w_pick_base);
    assign w_any       = |i_req;
    assign w_release   = (r_state == S_GRANT) &&
                         (!i_req[r_sel] || (r_hold_cnt == HW'(HOLD_CYCLES)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next_state = S_GRANT;
            S_GRANT: if (w_release && !w_any) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gnt        <= 4'b0000;
            r_sel        <= 2'd0;
            r_last       <= 2'd3;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_hold_cnt   <= '0;
        end else if (r_state == S_IDLE) begin
            r_dout_valid <= 1'b0;
            if (w_any) begin
                r_gnt      <= 4'b0001 << w_pick;
                r_sel      <= w_pick;
                r_hold_cnt <= HW'(1);
            end
        end else begin
            r_dout       <= i_din[int'(r_sel)*W +: W];
            r_dout_valid <= 1'b1;
            if (w_release) begin
                r_last <= r_sel;
                if (w_any) begin
                    r_gnt      <= 4'b0001 << w_pick;
                    r_sel      <= w_pick;
                    r_hold_cnt <= HW'(1);
                end else begin
                    r_gnt      <= 4'b0000;
                    r_hold_cnt <= '0;
                end
            end else begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end
        end
    end

    always_comb begin
        o_busy       = (r_state == S_GRANT);
        o_gnt        = r_gnt;
        o_sel        = r_sel;
        o_dout       = r_dout;
        o_dout_valid = r_dout_valid;
    end

endmodule
